mem_stage_sequencer: RTL and testbench

Memory-stage sequencer that consumes the EX/MEM pipeline buffer outputs and services 3-lane vector loads/stores against a single-port data memory, one lane per cycle. It drives a stall back to the EX/MEM buffer, which holds while stall is high. It presents the assembled lane results plus forwarded control to the MEM/WB buffer with a one-cycle valid strobe.

---
 rtl/mem_stage_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_mem_stage_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_sequencer.sv
// Memory-stage sequencer: walks 3-lane vector loads/stores through a single-port
// data memory one lane per cycle, then hands assembled lanes to the MEM/WB buffer.

module mem_stage_lane #(
    parameter int N = 18
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         op_cap,
    input  logic         alu_cap,
    input  logic         rd_cap,
    input  logic         st_pres,
    input  logic         ld_pres,
    input  logic [N-1:0] addr_in,
    input  logic [N-1:0] wdata_in,
    input  logic [N-1:0] rdata,
    output logic [N-1:0] addr_q,
    output logic [N-1:0] wdata_q,
    output logic [N-1:0] read_o,
    output logic [N-1:0] alu_o
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            read_o  <= '0;
            alu_o   <= '0;
        end else begin
            if (op_cap) begin
                addr_q  <= addr_in;
                wdata_q <= wdata_in;
            end
            if (alu_cap) begin
                alu_o  <= addr_in;
                read_o <= '0;
            end
            if (rd_cap)
                read_o <= rdata;
            // stores report zero read data; loads keep what was captured per lane
            if (st_pres) begin
                alu_o  <= addr_q;
                read_o <= '0;
            end
            if (ld_pres)
                alu_o <= addr_q;
        end
    end
endmodule

module mem_stage_sequencer #(
    parameter int N = 18
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid,
    input  logic [2:0][N-1:0]   aluResult,
    input  logic [2:0][N-1:0]   writeData,
    input  logic [3:0]          WA3,
    input  logic                PCSrc,
    input  logic                RegWrite,
    input  logic                MemtoReg,
    input  logic                MemWrite,
    output logic                stall,
    output logic [N-1:0]        memAddr,
    output logic [N-1:0]        memWData,
    output logic                memWE,
    output logic                memRE,
    input  logic [N-1:0]        memRData,
    output logic                wbValid,
    output logic [2:0][N-1:0]   readDataO,
    output logic [2:0][N-1:0]   aluResultO,
    output logic [3:0]          WA3O,
    output logic                PCSrcO,
    output logic                RegWriteO,
    output logic                MemtoRegO
);
    localparam int LANES = 3;

    typedef enum logic [1:0] {IDLE, STORE, LOAD, DRAIN} state_t;

    state_t state, state_n;
    logic [1:0] lane, lane_n;
    logic accept, alu_acc, mem_acc, st_done, ld_done;
    logic [LANES-1:0] rd_cap;
    logic [LANES-1:0][N-1:0] addr_q, wdata_q;
    logic [3:0] wa3_q;
    logic pcsrc_q, regwrite_q, memtoreg_q;

    assign accept  = valid && (state == IDLE);
    assign alu_acc = accept && !MemWrite && !MemtoReg;
    assign mem_acc = accept && (MemWrite || MemtoReg);
    assign st_done = (state == STORE) && (lane == 2'd2);
    assign ld_done = (state == DRAIN);

    // read data arrives one cycle after issue, so capture trails the lane counter
    assign rd_cap[0] = (state == LOAD) && (lane == 2'd1);
    assign rd_cap[1] = (state == LOAD) && (lane == 2'd2);
    assign rd_cap[2] = ld_done;

    // stall comes straight from a flop so the EX/MEM load enable never glitches
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            lane  <= 2'd0;
            stall <= 1'b0;
        end else begin
            state <= state_n;
            lane  <= lane_n;
            stall <= (state_n != IDLE);
        end
    end

    always_comb begin
        state_n = state;
        lane_n  = lane;
        case (state)
            IDLE: begin
                lane_n = 2'd0;
                if (mem_acc)
                    state_n = MemWrite ? STORE : LOAD;
            end
            STORE: begin
                if (lane == 2'd2) begin
                    state_n = IDLE;
                    lane_n  = 2'd0;
                end else begin
                    lane_n = lane + 2'd1;
                end
            end
            LOAD: begin
                if (lane == 2'd2) begin
                    state_n = DRAIN;
                    lane_n  = 2'd0;
                end else begin
                    lane_n = lane + 2'd1;
                end
            end
            DRAIN: state_n = IDLE;
            default: begin
                state_n = IDLE;
                lane_n  = 2'd0;
            end
        endcase
    end

    always_comb begin
        memWE    = 1'b0;
        memRE    = 1'b0;
        memAddr  = '0;
        memWData = '0;
        if (state == STORE || state == LOAD) begin
            memWE = (state == STORE);
            memRE = (state == LOAD);
            case (lane)
                2'd0:    memAddr = addr_q[0];
                2'd1:    memAddr = addr_q[1];
                default: memAddr = addr_q[2];
            endcase
            if (state == STORE) begin
                case (lane)
                    2'd0:    memWData = wdata_q[0];
                    2'd1:    memWData = wdata_q[1];
                    default: memWData = wdata_q[2];
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wbValid    <= 1'b0;
            wa3_q      <= '0;
            pcsrc_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            WA3O       <= '0;
            PCSrcO     <= 1'b0;
            RegWriteO  <= 1'b0;
            MemtoRegO  <= 1'b0;
        end else begin
            wbValid <= alu_acc || st_done || ld_done;
            if (mem_acc) begin
                wa3_q      <= WA3;
                pcsrc_q    <= PCSrc;
                regwrite_q <= RegWrite;
                memtoreg_q <= MemtoReg;
            end
            if (alu_acc) begin
                WA3O      <= WA3;
                PCSrcO    <= PCSrc;
                RegWriteO <= RegWrite;
                MemtoRegO <= MemtoReg;
            end
            if (st_done || ld_done) begin
                WA3O      <= wa3_q;
                PCSrcO    <= pcsrc_q;
                RegWriteO <= regwrite_q;
                MemtoRegO <= memtoreg_q;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mem_stage_lane #(.N(N)) u_lane (
            .clk      (clk),
            .reset    (reset),
            .op_cap   (mem_acc),
            .alu_cap  (alu_acc),
            .rd_cap   (rd_cap[i]),
            .st_pres  (st_done),
            .ld_pres  (ld_done),
            .addr_in  (aluResult[i]),
            .wdata_in (writeData[i]),
            .rdata    (memRData),
            .addr_q   (addr_q[i]),
            .wdata_q  (wdata_q[i]),
            .read_o   (readDataO[i]),
            .alu_o    (aluResultO[i])
        );
    end
endmodule

// File: tb/tb_mem_stage_sequencer.sv
// Bench for mem_stage_sequencer: directed ops plus random ops, checked every cycle
// against a per-cycle expectation timeline built from the op latencies.

module tb_mem_stage_sequencer;
    localparam int N    = 18;
    localparam int MAXC = 8192;

    typedef struct packed {
        logic [2:0][N-1:0] a;
        logic [2:0][N-1:0] w;
        logic [3:0]        wa3;
        logic              pc, rw, m2r, mw;
    } op_t;

    typedef struct packed {
        logic [2:0][N-1:0] rd;
        logic [2:0][N-1:0] alu;
        logic [3:0]        wa3;
        logic              pc, rw, m2r;
    } wb_t;

    logic clk = 0, reset = 1, valid = 0;
    logic [2:0][N-1:0] aluResult = '0, writeData = '0;
    logic [3:0] WA3 = '0;
    logic PCSrc = 0, RegWrite = 0, MemtoReg = 0, MemWrite = 0;
    logic stall, memWE, memRE, wbValid;
    logic [N-1:0] memAddr, memWData;
    logic [N-1:0] memRData = '0;
    logic [2:0][N-1:0] readDataO, aluResultO;
    logic [3:0] WA3O;
    logic PCSrcO, RegWriteO, MemtoRegO;

    mem_stage_sequencer #(.N(N)) dut (
        .clk(clk), .reset(reset), .valid(valid),
        .aluResult(aluResult), .writeData(writeData), .WA3(WA3),
        .PCSrc(PCSrc), .RegWrite(RegWrite), .MemtoReg(MemtoReg), .MemWrite(MemWrite),
        .stall(stall), .memAddr(memAddr), .memWData(memWData),
        .memWE(memWE), .memRE(memRE), .memRData(memRData),
        .wbValid(wbValid), .readDataO(readDataO), .aluResultO(aluResultO),
        .WA3O(WA3O), .PCSrcO(PCSrcO), .RegWriteO(RegWriteO), .MemtoRegO(MemtoRegO)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [N-1:0] pat(input int a);
        return N'(a * 37 + 5);
    endfunction

    // data memory the DUT talks to; unwritten words read back as pat(addr)
    logic [N-1:0] mem [256];
    bit           wr  [256];
    always @(posedge clk) begin
        if (memWE) begin
            mem[memAddr[7:0]] <= memWData;
            wr[memAddr[7:0]]  <= 1'b1;
        end
        if (memRE)
            memRData <= wr[memAddr[7:0]] ? mem[memAddr[7:0]] : pat(int'(memAddr[7:0]));
    end

    function automatic logic [N-1:0] phys(input int a);
        return wr[a] ? mem[a] : pat(a);
    endfunction

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    // expectation timeline, indexed by cycle
    bit           e_stall [MAXC];
    bit           e_wb    [MAXC];
    bit           e_we    [MAXC];
    bit           e_re    [MAXC];
    logic [N-1:0] e_addr  [MAXC];
    logic [N-1:0] e_wd    [MAXC];
    wb_t          e_rec   [MAXC];
    logic [N-1:0] ref_mem [256];
    int           free_c = 0;
    bit           chk_en = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", 32'(stall), 32'(e_stall[cyc]));
            chk("wbValid", 32'(wbValid), 32'(e_wb[cyc]));
            chk("memWE", 32'(memWE), 32'(e_we[cyc]));
            chk("memRE", 32'(memRE), 32'(e_re[cyc]));
            chk("memAddr", 32'(memAddr), 32'(e_addr[cyc]));
            chk("memWData", 32'(memWData), 32'(e_wd[cyc]));
            if (e_wb[cyc]) begin
                for (int l = 0; l < 3; l++) begin
                    chk("readDataO", 32'(readDataO[l]), 32'(e_rec[cyc].rd[l]));
                    chk("aluResultO", 32'(aluResultO[l]), 32'(e_rec[cyc].alu[l]));
                end
                chk("WA3O", 32'(WA3O), 32'(e_rec[cyc].wa3));
                chk("PCSrcO", 32'(PCSrcO), 32'(e_rec[cyc].pc));
                chk("RegWriteO", 32'(RegWriteO), 32'(e_rec[cyc].rw));
                chk("MemtoRegO", 32'(MemtoRegO), 32'(e_rec[cyc].m2r));
            end
        end
    end

    function automatic op_t mk(input logic [N-1:0] a0, a1, a2, w0, w1, w2,
                               input logic [3:0] wa3, input logic pc, rw, m2r, mw);
        op_t o;
        o.a[0] = a0; o.a[1] = a1; o.a[2] = a2;
        o.w[0] = w0; o.w[1] = w1; o.w[2] = w2;
        o.wa3 = wa3; o.pc = pc; o.rw = rw; o.m2r = m2r; o.mw = mw;
        return o;
    endfunction

    task automatic drive(input op_t o);
        valid = 1'b1;
        aluResult = o.a; writeData = o.w; WA3 = o.wa3;
        PCSrc = o.pc; RegWrite = o.rw; MemtoReg = o.m2r; MemWrite = o.mw;
    endtask

    task automatic junk(input bit v);
        valid = v;
        for (int l = 0; l < 3; l++) begin
            aluResult[l] = N'($urandom);
            writeData[l] = N'($urandom);
        end
        WA3 = 4'($urandom);
        PCSrc = 1'($urandom); RegWrite = 1'($urandom);
        MemtoReg = 1'($urandom); MemWrite = 1'($urandom);
    endtask

    // latency model: ALU wb +1; store wb +4 (stall 3); load wb +5 (stall 4)
    task automatic model(input op_t o, input int c);
        wb_t r;
        r.alu = o.a; r.rd = '0; r.wa3 = o.wa3; r.pc = o.pc; r.rw = o.rw; r.m2r = o.m2r;
        if (o.mw) begin
            for (int k = 0; k < 3; k++) begin
                e_stall[c+1+k] = 1; e_we[c+1+k] = 1;
                e_addr[c+1+k] = o.a[k]; e_wd[c+1+k] = o.w[k];
                ref_mem[o.a[k][7:0]] = o.w[k];
            end
            e_wb[c+4] = 1; e_rec[c+4] = r; free_c = c + 4;
        end else if (o.m2r) begin
            for (int k = 0; k < 3; k++) begin
                e_re[c+1+k] = 1; e_addr[c+1+k] = o.a[k];
                r.rd[k] = ref_mem[o.a[k][7:0]];
            end
            for (int k = 1; k <= 4; k++) e_stall[c+k] = 1;
            e_wb[c+5] = 1; e_rec[c+5] = r; free_c = c + 5;
        end else begin
            e_wb[c+1] = 1; e_rec[c+1] = r; free_c = c + 1;
        end
    endtask

    task automatic run_op(input op_t o, input bit hold, output int acc_c);
        bit done = 0;
        acc_c = -1;
        for (int i = 0; i < 10 && !done; i++) begin
            @(posedge clk); #1;
            if (cyc >= free_c) begin
                drive(o); model(o, cyc); acc_c = cyc; done = 1;
            end else if (hold) drive(o);
            else junk(1'($urandom));
        end
        if (!done) chk("run_op_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            junk(1'b0);
        end
    endtask

    task automatic wait_wb(input int bound, output int at, output int nstall);
        at = -1; nstall = 0;
        for (int i = 0; i < bound && at < 0; i++) begin
            @(posedge clk); #1;
            junk(1'b0);
            if (stall) nstall++;
            if (wbValid) at = cyc;
        end
        if (at < 0) chk("wb_timeout", 0, 1);
    endtask

    initial begin
        op_t o;
        int c, c2, at, ns;
        logic [N-1:0] old32;

        for (int i = 0; i < MAXC; i++) begin
            e_stall[i] = 0; e_wb[i] = 0; e_we[i] = 0; e_re[i] = 0;
            e_addr[i] = '0; e_wd[i] = '0; e_rec[i] = '0;
        end
        for (int a = 0; a < 256; a++) ref_mem[a] = pat(a);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 32'(stall), 0);
        chk("rst_wbValid", 32'(wbValid), 0);
        chk("rst_memWE", 32'(memWE), 0);
        chk("rst_memAddr", 32'(memAddr), 0);
        chk("rst_aluResultO", 32'(aluResultO[0]), 0);
        @(negedge clk); reset = 0;
        @(posedge clk); #1;
        chk_en = 1;

        // ALU op
        o = mk(5, 6, 7, 0, 0, 0, 4'd3, 0, 1, 0, 0);
        run_op(o, 0, c);
        wait_wb(10, at, ns);
        chk("alu_lat", 32'(at - c), 1);
        chk("alu_stall", 32'(ns), 0);
        chk("alu_o0", 32'(aluResultO[0]), 5);
        chk("alu_o2", 32'(aluResultO[2]), 7);
        chk("alu_wa3", 32'(WA3O), 3);

        // store
        o = mk('h10, 'h11, 'h12, 'hA, 'hB, 'hC, 4'd1, 0, 0, 0, 1);
        run_op(o, 0, c);
        wait_wb(10, at, ns);
        chk("st_lat", 32'(at - c), 4);
        chk("st_stall", 32'(ns), 3);
        chk("st_mem10", 32'(phys('h10)), 'hA);
        chk("st_mem12", 32'(phys('h12)), 'hC);

        // load the same words, permuted
        o = mk('h12, 'h10, 'h11, 0, 0, 0, 4'd7, 0, 1, 1, 0);
        run_op(o, 0, c);
        wait_wb(10, at, ns);
        chk("ld_lat", 32'(at - c), 5);
        chk("ld_stall", 32'(ns), 4);
        chk("ld_rd0", 32'(readDataO[0]), 'hC);
        chk("ld_rd1", 32'(readDataO[1]), 'hA);
        chk("ld_rd2", 32'(readDataO[2]), 'hB);

        // store followed by an ALU op held while stalled
        o = mk('h40, 'h41, 'h42, 1, 2, 3, 4'd2, 0, 0, 0, 1);
        run_op(o, 0, c);
        o = mk(9, 8, 7, 0, 0, 0, 4'd4, 1, 1, 0, 0);
        run_op(o, 1, c2);
        chk("held_accept", 32'(c2 - c), 4);
        idle(6);

        // MemWrite and MemtoReg together behave as a store
        o = mk('h20, 'h21, 'h22, 'h1, 'h2, 'h3, 4'd5, 0, 1, 1, 1);
        run_op(o, 0, c);
        wait_wb(10, at, ns);
        chk("both_lat", 32'(at - c), 4);
        chk("both_rd1", 32'(readDataO[1]), 0);
        chk("both_mem22", 32'(phys('h22)), 3);

        // reset while lane 2 of a store is on the bus
        old32 = phys('h32);
        o = mk('h30, 'h31, 'h32, 'h111, 'h222, 'h333, 4'd6, 1, 1, 0, 1);
        run_op(o, 0, c);
        idle(2);
        @(posedge clk); #1;
        chk("pre_rst_we", 32'(memWE), 1);
        chk_en = 0;
        reset = 1;
        #1;
        chk("mid_rst_stall", 32'(stall), 0);
        chk("mid_rst_we", 32'(memWE), 0);
        chk("mid_rst_addr", 32'(memAddr), 0);
        chk("mid_rst_alu0", 32'(aluResultO[0]), 0);
        chk("mid_rst_wa3", 32'(WA3O), 0);
        @(negedge clk); reset = 0;
        for (int i = c + 1; i < c + 10; i++) begin
            e_stall[i] = 0; e_wb[i] = 0; e_we[i] = 0; e_re[i] = 0;
            e_addr[i] = '0; e_wd[i] = '0;
        end
        ref_mem['h32] = old32;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            junk(1'b0);
            chk("abort_no_wb", 32'(wbValid), 0);
        end
        chk("abort_mem30", 32'(phys('h30)), 'h111);
        chk("abort_mem31", 32'(phys('h31)), 'h222);
        chk("abort_mem32", 32'(phys('h32)), 32'(old32));
        free_c = cyc;
        chk_en = 1;

        // random ops
        for (int n = 0; n < 200; n++) begin
            int kind;
            kind = $urandom_range(0, 3);
            for (int l = 0; l < 3; l++) begin
                o.a[l] = (kind == 0) ? N'($urandom) : N'($urandom_range(0, 63));
                o.w[l] = N'($urandom);
            end
            o.wa3 = 4'($urandom); o.pc = 1'($urandom); o.rw = 1'($urandom);
            o.mw  = (kind == 1 || kind == 3);
            o.m2r = (kind == 2 || kind == 3);
            run_op(o, 1'($urandom), c);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
